// File: rtl/regbank_16x20_wr.sv
// 16x20 register bank with FIFO-buffered writes and sequenced clear.
// Optional: REGBANK_ZERO_REG0_EN hardwires entry 0 to zero.
module regbank_16x20_wr #(
   parameter int NREG       = 16,
   parameter int WIDTH      = 20,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [3:0]                  wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        clr_start,
   output logic                        clr_busy,
   output logic [WIDTH-1:0][NREG-1:0]  bank_out,
   output logic [NREG-1:0]             dirty
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_t;

`ifdef REGBANK_ZERO_REG0_EN
   localparam bit ZERO0 = 1'b1;
`else
   localparam bit ZERO0 = 1'b0;
`endif

   localparam logic [2:0] FULL = 3'(FIFO_DEPTH);
   localparam logic [1:0] LAST = 2'(FIFO_DEPTH - 1);

   state_t state, state_nxt;

   logic [3:0]       f_addr [4];
   logic [WIDTH-1:0] f_data [4];
   logic [1:0]       rd_ptr, wr_ptr;
   logic [2:0]       cnt, cnt_nxt;
   logic             push, pop, we;
   logic [3:0]       head_addr;
   logic [WIDTH-1:0] head_data;
   logic [3:0]       k;

   logic [WIDTH-1:0] bank [NREG];
   logic [NREG-1:0]  dirty_q;

   assign wr_ready  = (state == IDLE) && (cnt != FULL);
   assign clr_busy  = (state != IDLE);
   assign push      = wr_valid && wr_ready;
   assign pop       = (state != CLEAR) && (cnt != 3'd0);
   assign head_addr = f_addr[rd_ptr];
   assign head_data = f_data[rd_ptr];
   assign we        = !(ZERO0 && (head_addr == 4'd0));
   assign dirty     = dirty_q;

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      cnt_nxt = cnt;
      unique case ({push, pop})
         2'b10:   cnt_nxt = cnt + 3'd1;
         2'b01:   cnt_nxt = cnt - 3'd1;
         default: cnt_nxt = cnt;
      endcase
   end

   // Next-state: drain pending writes, then sweep all entries to zero.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (clr_start) state_nxt = DRAIN;
         DRAIN:   if (cnt_nxt == 3'd0) state_nxt = CLEAR;
         CLEAR:   if (k == 4'hF) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, FIFO pointers/occupancy and clear index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         cnt    <= 3'd0;
         k      <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
         if (state == CLEAR)
            k <= k + 4'd1;
         else
            k <= 4'd0;
      end
   end

   // FIFO payload storage; validity is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (push) begin
         f_addr[wr_ptr] <= wr_addr;
         f_data[wr_ptr] <= wr_data;
      end
   end

   // Commit the FIFO head, or zero entry k during the clear sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NREG; j++)
            bank[j] <= '0;
         dirty_q <= '0;
      end else if (state == CLEAR) begin
         bank[k]    <= '0;
         dirty_q[k] <= 1'b0;
      end else if (pop && we) begin
         bank[head_addr]    <= head_data;
         dirty_q[head_addr] <= 1'b1;
      end
   end

   // Bit-transpose into the per-lane layout the read-select consumes.
   always_comb begin
      bank_out = '0;
      for (int i = 0; i < WIDTH; i++)
         for (int j = 0; j < NREG; j++)
            bank_out[i][j] = bank[j][i];
   end

endmodule
